apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  Upstream APB requester that drives the team's APB memory slave.
//  - Accepts single read/write commands on a valid/ready command port.
//  - Sequences each command through the APB IDLE->SETUP->ACCESS phases and waits on P_ready.
//  - Returns read data and error status as a one-cycle response pulse.
// PARAMETERS
//  ADDR_width      4   APB address width in bits
//  DATA_width      8   APB data width in bits
//  TIMEOUT_CYCLES  16  ACCESS-phase cycles allowed before abort; used only with APB_TIMEOUT_EN; must be >=1
// PORTS
//  P_clk      in   1           clock; all logic on rising edge
//  P_reset_n  in   1           asynchronous active-low reset
//  cmd_valid  in   1           command request
//  cmd_ready  out  1           command accepted when cmd_valid && cmd_ready
//  cmd_write  in   1           1 = write, 0 = read
//  cmd_addr   in   ADDR_width  target address
//  cmd_wdata  in   DATA_width  write data
//  rsp_valid  out  1           one-cycle completion pulse
//  rsp_rdata  out  DATA_width  read data; 0 for writes and aborts
//  rsp_err    out  1           P_slverr captured, or timeout abort
//  P_sel      out  1           APB select
//  P_enable   out  1           APB enable
//  P_write    out  1           APB direction
//  P_addr     out  ADDR_width  APB address
//  P_wdata    out  DATA_width  APB write data
//  P_rdata    in   DATA_width  APB read data
//  P_ready    in   1           APB transfer complete
//  P_slverr   in   1           APB slave error
// BEHAVIOUR
//  - Reset: async, active-low. Every output clears to 0 and the FSM enters IDLE. No response is issued.
//  - States: IDLE, SETUP, ACCESS. All outputs are registered.
//  - cmd_ready = (state==IDLE). A command arriving while busy is not accepted; the requester holds it.
//  - IDLE: on accept, latch write/addr/wdata into P_write/P_addr/P_wdata; go to SETUP.
//  - SETUP (1 cycle): P_sel=1, P_enable=0; go to ACCESS.
//  - ACCESS: P_sel=1, P_enable=1. P_addr/P_wdata/P_write stay stable until completion.
//  - Completion: a rising edge in ACCESS with P_ready=1.
//    - Capture P_rdata (reads only) and P_slverr.
//    - Drop P_sel/P_enable; go to IDLE.
//    - rsp_valid=1 for exactly one cycle.
//  - P_ready outside ACCESS is ignored, including a stale-high P_ready from the slave.
//  - Latency: accept at edge N, SETUP in cycle N+1, ACCESS in N+2. With zero wait states, rsp_valid is high in cycle N+3.
//  - Each wait state (P_ready=0 in ACCESS) adds one cycle.
//  - Back-to-back: a new command may be accepted in the same cycle rsp_valid is high. It always passes through SETUP; there is never ACCESS->ACCESS.
//  - In IDLE, P_addr/P_wdata/P_write hold their last values.
//  - rsp_valid/rsp_err/rsp_rdata: rsp_valid is 0 except during the pulse. rsp_rdata/rsp_err hold until the next completion.
//  - No response backpressure: the consumer must take rsp_* in the pulse cycle.
//  - Reset mid-transfer: everything clears immediately; the pending command is dropped without a response.
// CONFIGURATION
//  APB_TIMEOUT_EN defined:
//   - A counter runs in ACCESS, clears on entry to SETUP, and is $clog2(TIMEOUT_CYCLES+1) bits wide.
//   - After TIMEOUT_CYCLES ACCESS cycles without P_ready: abort to IDLE, rsp_valid=1, rsp_err=1, rsp_rdata=0.
//   - P_ready=1 on the limit cycle wins: normal completion.
//  APB_TIMEOUT_EN undefined:
//   - No counter; ACCESS waits on P_ready indefinitely.
//   - TIMEOUT_CYCLES is ignored; rsp_err reflects P_slverr only.
// STRUCTURE
//  - apb_pkg: state encoding localparams ST_IDLE=2'd0, ST_SETUP=2'd1, ST_ACCESS=2'd2.
//    Shared with the slave-side bench.
//  - Sub-module apb_timeout_counter (enable, clear, expired), instantiated only under APB_TIMEOUT_EN.
//  - FSM and datapath registers live in this module.
// TESTING
//  1. Write addr=3, data=0xA5, zero-wait slave -> SETUP then ACCESS, P_addr=3, P_wdata=0xA5, P_write=1;
//     rsp_valid in cycle N+3, rsp_err=0, rsp_rdata=0.
//  2. Read addr=3 after test 1 -> P_write=0; rsp_rdata=0xA5, rsp_err=0.
//  3. Slave holds P_ready=0 for 5 ACCESS cycles -> P_sel/P_enable/P_addr stable 6 cycles;
//     rsp_valid at N+8; cmd_ready=0 throughout.
//  4. P_slverr=1 with P_ready on read addr=7 -> rsp_err=1; the next clean transfer returns rsp_err=0.
//  5. APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, P_ready tied 0 -> abort after 16 ACCESS cycles:
//     rsp_err=1, rsp_rdata=0, P_sel=0 next cycle.
//  6. Assert P_reset_n=0 mid-ACCESS -> all outputs 0 asynchronously, no rsp_valid;
//     after release, a new command completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB state encoding for the master bridge and the slave-side bench.
package apb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_SETUP  = ST_SETUP,
    S_ACCESS = ST_ACCESS
  } apb_state_e;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response port plus APB bus of the master bridge.
// master = bridge side, slave = requester/APB-slave environment side.
interface apb_master_bridge_if #(
  parameter int ADDR_width = 4,
  parameter int DATA_width = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_width-1:0] cmd_addr;
  logic [DATA_width-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [DATA_width-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  P_sel;
  logic                  P_enable;
  logic                  P_write;
  logic [ADDR_width-1:0] P_addr;
  logic [DATA_width-1:0] P_wdata;
  logic [DATA_width-1:0] P_rdata;
  logic                  P_ready;
  logic                  P_slverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, P_rdata, P_ready, P_slverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           P_sel, P_enable, P_write, P_addr, P_wdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, P_rdata, P_ready, P_slverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           P_sel, P_enable, P_write, P_addr, P_wdata
  );
endinterface

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS-phase cycles; expired flags the LIMIT-th ACCESS cycle.
module apb_timeout_counter #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  localparam logic [W-1:0] TOP  = W'(LIMIT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt <= '0;
    else if (clear)                 cnt <= '0;
    else if (enable && cnt != TOP)  cnt <= cnt + 1'b1;
  end

  // cnt holds the index of the current ACCESS cycle (0-based).
  assign expired = enable && (cnt == LAST);
endmodule

// File: rtl/apb_master_bridge.sv
// Single-command APB requester: IDLE -> SETUP -> ACCESS, one-cycle response pulse.
// Optional ACCESS-phase abort when APB_TIMEOUT_EN is defined.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_width     = 4,
  parameter int DATA_width     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic               P_clk,
  input logic               P_reset_n,
  apb_master_bridge_if.master bus
);
  apb_state_e state_q, state_d;
  logic       accept, done, abort, expired;

  assign accept = bus.cmd_valid && bus.cmd_ready && (state_q == S_IDLE);
  assign done   = (state_q == S_ACCESS) && bus.P_ready;
  assign abort  = (state_q == S_ACCESS) && !bus.P_ready && expired;

`ifdef APB_TIMEOUT_EN
  apb_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk     (P_clk),
    .rst_n   (P_reset_n),
    .enable  (state_q == S_ACCESS),
    .clear   (accept),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge P_clk or negedge P_reset_n) begin
    if (!P_reset_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (done || abort) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the phase.
  always_ff @(posedge P_clk or negedge P_reset_n) begin
    if (!P_reset_n) begin
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.P_sel     <= 1'b0;
      bus.P_enable  <= 1'b0;
      bus.P_write   <= 1'b0;
      bus.P_addr    <= '0;
      bus.P_wdata   <= '0;
    end else begin
      bus.cmd_ready <= (state_d == S_IDLE);
      bus.P_sel     <= (state_d != S_IDLE);
      bus.P_enable  <= (state_d == S_ACCESS);
      bus.rsp_valid <= done || abort;
      if (accept) begin
        bus.P_write <= bus.cmd_write;
        bus.P_addr  <= bus.cmd_addr;
        bus.P_wdata <= bus.cmd_wdata;
      end
      if (done) begin
        bus.rsp_err   <= bus.P_slverr;
        bus.rsp_rdata <= bus.P_write ? '0 : bus.P_rdata;
      end else if (abort) begin
        bus.rsp_err   <= 1'b1;
        bus.rsp_rdata <= '0;
      end
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench for apb_master_bridge with a memory-backed APB slave model.
module tb_apb_master_bridge;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int TO = 16;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int OW = 6 + 2*DW + AW;

  logic P_clk = 1'b0;
  logic P_reset_n = 1'b0;
  always #5 P_clk = ~P_clk;

  apb_master_bridge_if #(.ADDR_width(AW), .DATA_width(DW)) bus();

  apb_master_bridge #(.ADDR_width(AW), .DATA_width(DW), .TIMEOUT_CYCLES(TO)) dut (
    .P_clk     (P_clk),
    .P_reset_n (P_reset_n),
    .bus       (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] mem [16];
  logic [DW-1:0] last_rdata;
  logic          last_err;

  function automatic logic [OW-1:0] outs();
    return {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.P_sel,
            bus.P_enable, bus.P_write, bus.P_addr, bus.P_wdata};
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.P_ready  = 1'($urandom_range(0, 1));
      bus.P_slverr = 1'($urandom_range(0, 1));
      bus.P_rdata  = DW'($urandom);
      @(posedge P_clk); #1;
      checks++;
      if ({bus.cmd_ready, bus.rsp_valid, bus.P_sel, bus.P_enable, bus.rsp_err, bus.rsp_rdata}
          !== {1'b1, 1'b0, 1'b0, 1'b0, last_err, last_rdata}) begin
        failures++;
        $display("FAIL idle got rdy=%b vld=%b sel=%b en=%b err=%b rd=%h exp 1 0 0 0 err=%b rd=%h",
                 bus.cmd_ready, bus.rsp_valid, bus.P_sel, bus.P_enable, bus.rsp_err,
                 bus.rsp_rdata, last_err, last_rdata);
      end
    end
    bus.P_ready = 1'b0;
  endtask

  // One command; slave inserts 'waits' wait states. Returns in the response pulse cycle.
  task automatic do_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int waits, input bit err, input string nm);
    bit aborted, last, to;
    logic [DW-1:0] exp_rd;
    logic exp_err;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.P_ready   = 1'($urandom_range(0, 1));
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s cmd_ready got=%b exp=1", nm, bus.cmd_ready);
    end
    @(posedge P_clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = AW'($urandom);
    bus.cmd_wdata = DW'($urandom);
    checks++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.P_sel, bus.P_enable, bus.P_write, bus.P_addr, bus.P_wdata}
        !== {1'b0, 1'b0, 1'b1, 1'b0, wr, a, d}) begin
      failures++;
      $display("FAIL %s setup got rdy=%b vld=%b sel=%b en=%b w=%b a=%h d=%h exp 0 0 1 0 w=%b a=%h d=%h",
               nm, bus.cmd_ready, bus.rsp_valid, bus.P_sel, bus.P_enable, bus.P_write,
               bus.P_addr, bus.P_wdata, wr, a, d);
    end
    bus.P_ready = 1'b1;  // stale-high ready during SETUP must be ignored
    @(posedge P_clk); #1;
    aborted = 1'b0;
    for (int k = 0; k <= waits; k++) begin
      last = (k == waits);
      to   = TO_EN && (k == TO - 1) && !last;
      checks++;
      if ({bus.cmd_ready, bus.rsp_valid, bus.P_sel, bus.P_enable, bus.P_write, bus.P_addr, bus.P_wdata}
          !== {1'b0, 1'b0, 1'b1, 1'b1, wr, a, d}) begin
        failures++;
        $display("FAIL %s access%0d got rdy=%b vld=%b sel=%b en=%b w=%b a=%h d=%h exp 0 0 1 1 w=%b a=%h d=%h",
                 nm, k, bus.cmd_ready, bus.rsp_valid, bus.P_sel, bus.P_enable, bus.P_write,
                 bus.P_addr, bus.P_wdata, wr, a, d);
      end
      bus.P_ready  = last;
      bus.P_slverr = last ? err : 1'($urandom_range(0, 1));
      bus.P_rdata  = (!wr && last) ? mem[a] : DW'($urandom);
      @(posedge P_clk); #1;
      if (to) begin
        aborted = 1'b1;
        break;
      end
    end
    bus.P_ready  = 1'b0;
    bus.P_slverr = 1'b0;
    exp_err = aborted ? 1'b1 : err;
    exp_rd  = (aborted || wr) ? '0 : mem[a];
    if (wr && !aborted && !err) mem[a] = d;
    checks++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.P_sel, bus.P_enable, bus.P_addr}
        !== {1'b1, 1'b1, exp_err, exp_rd, 1'b0, 1'b0, a}) begin
      failures++;
      $display("FAIL %s rsp got rdy=%b vld=%b err=%b rd=%h sel=%b en=%b a=%h exp 1 1 err=%b rd=%h 0 0 a=%h",
               nm, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.P_sel,
               bus.P_enable, bus.P_addr, exp_err, exp_rd, a);
    end
    last_rdata = exp_rd;
    last_err   = exp_err;
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.P_rdata = '0; bus.P_ready = 1'b0; bus.P_slverr = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
    last_rdata = '0; last_err = 1'b0;
    #3;
    checks++;
    if (outs() !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", outs());
    end
    #19 P_reset_n = 1'b1;
    @(posedge P_clk); #1;
    checks++;
    if (outs() !== {1'b1, {(OW-1){1'b0}}}) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h", outs(), {1'b1, {(OW-1){1'b0}}});
    end
    idle_cycles(2);
  endtask

  task automatic test_write_read();
    do_txn(1'b1, 4'd3, 8'hA5, 0, 1'b0, "write3");
    idle_cycles(1);
    do_txn(1'b0, 4'd3, 8'h00, 0, 1'b0, "read3");
    checks++;
    if (bus.rsp_rdata !== 8'hA5) begin
      failures++;
      $display("FAIL read3_value got=%h exp=a5", bus.rsp_rdata);
    end
    idle_cycles(2);
  endtask

  task automatic test_wait_states();
    do_txn(1'b1, 4'd5, DW'($urandom), 5, 1'b0, "wait5");
    idle_cycles(1);
    do_txn(1'b0, 4'd5, 8'h00, 5, 1'b0, "wait5_rd");
    idle_cycles(1);
  endtask

  task automatic test_slverr();
    do_txn(1'b0, 4'd7, 8'h00, 1, 1'b1, "slverr");
    checks++;
    if (bus.rsp_err !== 1'b1) begin
      failures++;
      $display("FAIL slverr_flag got=%b exp=1", bus.rsp_err);
    end
    idle_cycles(1);
    do_txn(1'b0, 4'd7, 8'h00, 0, 1'b0, "after_err");
    checks++;
    if (bus.rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL after_err_flag got=%b exp=0", bus.rsp_err);
    end
    idle_cycles(1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      do_txn(1'(i % 2 == 0), AW'(i), DW'($urandom), i % 3, 1'b0, "b2b");
    idle_cycles(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_txn(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), $urandom_range(0, 4),
             ($urandom_range(0, 5) == 0), "rand");
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 2));
    end
    idle_cycles(2);
  endtask

  task automatic test_timeout();
    do_txn(1'b1, 4'd2, 8'h3C, TO + 5, 1'b0, "timeout");
    checks++;
    if ({bus.rsp_err, bus.rsp_rdata} !== {1'b1, 8'h00}) begin
      failures++;
      $display("FAIL timeout_abort got err=%b rd=%h exp err=1 rd=00", bus.rsp_err, bus.rsp_rdata);
    end
    idle_cycles(1);
    do_txn(1'b0, 4'd2, 8'h00, TO - 1, 1'b0, "limit_ready");
    checks++;
    if (bus.rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL limit_ready_err got=%b exp=0", bus.rsp_err);
    end
    idle_cycles(1);
  endtask

  task automatic test_reset_mid();
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 4'd9; bus.cmd_wdata = 8'h5A;
    @(posedge P_clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge P_clk); #1;
    bus.P_ready = 1'b0;
    #2 P_reset_n = 1'b0;
    #1;
    checks++;
    if (outs() !== '0) begin
      failures++;
      $display("FAIL reset_mid_async got=%h exp=0", outs());
    end
    @(posedge P_clk); #1;
    checks++;
    if (outs() !== '0) begin
      failures++;
      $display("FAIL reset_mid_hold got=%h exp=0", outs());
    end
    #3 P_reset_n = 1'b1;
    last_rdata = '0; last_err = 1'b0;
    @(posedge P_clk); #1;
    checks++;
    if (outs() !== {1'b1, {(OW-1){1'b0}}}) begin
      failures++;
      $display("FAIL reset_mid_release got=%h exp=%h", outs(), {1'b1, {(OW-1){1'b0}}});
    end
    do_txn(1'b0, 4'd9, 8'h00, 2, 1'b0, "post_reset");
    idle_cycles(1);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wait_states();
    test_slverr();
    test_back_to_back();
    test_random();
    if (TO_EN) test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
